// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction prefetch queue.
// Contents: XLEN, INSTR_ALIGN_MASK, fetch_state_t (FSM states), fetch_entry_t (queued word + PC).
package fetch_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] INSTR_ALIGN_MASK = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      WAIT_DROP
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: bundles the redirect, instruction-memory and decode-side signals.
// master modport: the prefetch queue (drives imem_req/imem_addr, out_*, count).
// slave modport : the surrounding pipeline and memory (drives redirect*, imem_gnt/rvalid/rdata, out_ready).
interface fetch_queue_if
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) ();

   logic                    redirect;
   logic [XLEN-1:0]         redirect_pc;
   logic                    imem_req;
   logic [XLEN-1:0]         imem_addr;
   logic                    imem_gnt;
   logic                    imem_rvalid;
   logic [XLEN-1:0]         imem_rdata;
   logic                    out_valid;
   logic [XLEN-1:0]         out_instr;
   logic [XLEN-1:0]         out_pc;
   logic [XLEN-1:0]         out_npc;
   logic                    out_ready;
   logic [$clog2(DEPTH):0]  count;

   modport master (
      input  redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, out_ready,
      output imem_req, imem_addr, out_valid, out_instr, out_pc, out_npc, count
   );

   modport slave (
      output redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, out_ready,
      input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_npc, count
   );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t, DEPTH entries (power of two).
// Ports: clock, reset (sync, active high), flush, push, pop, din, dout (head entry), count.
// flush has priority over push and pop. Callers never push when full nor pop when empty.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   push,
   input  logic                   pop,
   input  fetch_entry_t           din,
   output fetch_entry_t           dout,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   fetch_entry_t    mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;

   // storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue between instruction memory and IF/ID.
// Ports: clock, reset (sync, active high), bus (fetch_queue_if.master):
//   redirect/redirect_pc   - taken branch flush and restart target
//   imem_req/addr/gnt      - single-outstanding fetch request
//   imem_rvalid/rdata      - fetch response
//   out_valid/instr/pc/npc - head of queue, consumed when out_ready
//   count                  - occupied entries
// Option: FETCH_QUEUE_BYPASS_EN forwards a kept response straight to the outputs when the
// queue is empty; undefined, all outputs come from registered queue state.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input logic           clock,
   input logic           reset,
   fetch_queue_if.master bus
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   fetch_state_t     state;
   fetch_state_t     state_next;
   logic [XLEN-1:0]  fetch_pc;
   logic [XLEN-1:0]  req_pc;
   logic [CW-1:0]    fifo_count;
   fetch_entry_t     head;
   fetch_entry_t     rsp_entry;
   logic             can_req;
   logic             grant;
   logic             rsp_kept;
   logic             head_valid;
   logic             push;
   logic             pop;
   logic [XLEN-1:0]  out_pc;

   // a request is only issued with a free slot, which reserves room for its response
   assign can_req    = (state == IDLE) && (fifo_count < CW'(DEPTH));
   assign grant      = can_req && bus.imem_gnt;
   assign rsp_kept   = (state == WAIT) && bus.imem_rvalid && !bus.redirect;
   assign head_valid = (fifo_count != '0);
   assign rsp_entry  = '{pc: req_pc, instr: bus.imem_rdata};

   // state register
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // next state
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:      if (grant) state_next = bus.redirect ? WAIT_DROP : WAIT;
         WAIT:      if (bus.imem_rvalid) state_next = IDLE;
                    else if (bus.redirect) state_next = WAIT_DROP;
         WAIT_DROP: if (bus.imem_rvalid) state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   // FSM outputs; request held low during reset
   always_comb begin
      bus.imem_req = 1'b0;
      if (!reset && can_req) bus.imem_req = 1'b1;
   end

   // fetch address and address of the outstanding request
   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         req_pc   <= '0;
      end else begin
         if (bus.redirect) fetch_pc <= bus.redirect_pc & INSTR_ALIGN_MASK;
         else if (grant)   fetch_pc <= fetch_pc + XLEN'(4);
         if (grant) req_pc <= fetch_pc;
      end
   end

   assign bus.imem_addr = fetch_pc;

`ifdef FETCH_QUEUE_BYPASS_EN
   logic bypass;

   // empty queue: a kept response is presented directly and only stored if not taken
   assign bypass        = !head_valid && rsp_kept;
   assign push          = rsp_kept && !(bypass && bus.out_ready);
   assign bus.out_valid = head_valid || bypass;
   assign out_pc        = bypass ? req_pc : head.pc;
   assign bus.out_instr = bypass ? bus.imem_rdata : head.instr;
`else
   assign push          = rsp_kept;
   assign bus.out_valid = head_valid;
   assign out_pc        = head.pc;
   assign bus.out_instr = head.instr;
`endif

   // a redirect cancels the pop; the FIFO flush also overrides it
   assign pop         = head_valid && bus.out_ready && !bus.redirect;
   assign bus.out_pc  = out_pc;
   assign bus.out_npc = out_pc + XLEN'(4);
   assign bus.count   = fifo_count;

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .flush (bus.redirect),
      .push  (push),
      .pop   (pop),
      .din   (rsp_entry),
      .dout  (head),
      .count (fifo_count)
   );

endmodule
